// File: rtl/axi_frame_reader.sv
// axi_frame_reader: AXI read master fetching a strided 2-D frame into a downstream FIFO, with optional byte swap.
// Latency: arvalid rises two edges after the enable rise is sampled; each accepted R beat reaches the FIFO one cycle later.
// Backpressure: a burst issues only if FIFO occupancy plus reserved words leaves room for all of it; R is always ready.
module axi_frame_reader #(
   parameter int DATA_W  = 64,
   parameter int FIFO_AW = 5,
   parameter int MAX_OUT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arready,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   input  logic                cfg_blk_en,
   input  logic [12:0]         cfg_line_bytes,
   input  logic [10:0]         cfg_img_height,
   input  logic [15:0]         cfg_stride,
   input  logic [31:0]         cfg_map_ba,
   input  logic [7:0]          cfg_max_burst_length,
   input  logic [1:0]          cfg_swap_mode,
   input  logic [FIFO_AW:0]    fifo_words_used,
   output logic                fifo_push,
   output logic [DATA_W-1:0]   fifo_data,
   output logic                sts_busy,
   output logic                sts_done,
   output logic                sts_err
);
   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int BSH        = $clog2(BEAT_BYTES);
   localparam int RW         = FIFO_AW + 1;

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN, DONE} state_t;

   state_t            state;
   logic              en_q;
   logic              aborting;     // abort seen this frame; stays set until the next start
   logic [31:0]       addr;
   logic [31:0]       line_addr;
   logic [12:0]       rem;          // beats left in the current line
   logic [12:0]       beats;        // length of the burst currently on AR
   logic [10:0]       lines;
   logic [RW-1:0]     reserved;     // FIFO words promised to bursts but not yet pushed
   logic [2:0]        outstanding;

   logic              ar_hs, r_hs, last_hs, start, abort_req, discard, credit_ok, line_end;
   logic [12:0]       line_beats, max_beats, to_4k, beats_c, rem_after;
   logic [15:0]       credit_sum;
   logic [DATA_W-1:0] swapped;

   assign arsize     = 3'(BSH);
   assign arburst    = 2'b01;
   assign rready     = ~rst;

   assign ar_hs      = arvalid & arready;
   assign r_hs       = rvalid & rready;
   assign last_hs    = r_hs & rlast;
   assign start      = (state == IDLE) & cfg_blk_en & ~en_q;
   assign abort_req  = ~cfg_blk_en & ((state == LOAD) | (state == ISSUE) | (state == WAIT) | (state == DRAIN));
   assign discard    = aborting | abort_req;

   assign line_beats = cfg_line_bytes >> BSH;
   assign max_beats  = (cfg_max_burst_length == 8'd0) ? 13'd1 : {5'd0, cfg_max_burst_length};
   assign to_4k      = (13'd4096 - {1'b0, addr[11:0]}) >> BSH;
   assign rem_after  = rem - beats;
   assign line_end   = (rem_after == 13'd0);
   assign credit_sum = 16'(fifo_words_used) + 16'(reserved) + 16'(beats_c);
   assign credit_ok  = (credit_sum <= 16'(1 << FIFO_AW)) && (32'(outstanding) < MAX_OUT);

   // Next burst length: smallest of the burst cap, the rest of the line and the room left in the 4 KB page.
   always_comb begin
      beats_c = max_beats;
      if (rem < beats_c) beats_c = rem;
      if (to_4k < beats_c) beats_c = to_4k;
   end

   // Byte swap by reversing byte order inside groups of 2, 4 or all bytes (index XOR group-1).
   always_comb begin
      int mask;
      mask = 0;
      case (cfg_swap_mode)
         2'd1:    mask = 1;
         2'd2:    mask = 3;
         2'd3:    mask = BEAT_BYTES - 1;
         default: mask = 0;
      endcase
      swapped = '0;
      for (int i = 0; i < BEAT_BYTES; i++) begin
         swapped[8*i +: 8] = rdata[8*(i ^ mask) +: 8];
      end
   end

   // Control FSM with credit/outstanding accounting, R-to-FIFO path and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         en_q        <= 1'b0;
         aborting    <= 1'b0;
         addr        <= '0;
         line_addr   <= '0;
         rem         <= '0;
         beats       <= '0;
         lines       <= '0;
         reserved    <= '0;
         outstanding <= '0;
         arvalid     <= 1'b0;
         araddr      <= '0;
         arlen       <= '0;
         fifo_push   <= 1'b0;
         fifo_data   <= '0;
         sts_busy    <= 1'b0;
         sts_done    <= 1'b0;
         sts_err     <= 1'b0;
      end else begin
         en_q        <= cfg_blk_en;
         outstanding <= outstanding + 3'(ar_hs) - 3'(last_hs);
         reserved    <= reserved + RW'(ar_hs ? beats : 13'd0) - RW'(fifo_push);
         fifo_push   <= r_hs & ~discard;
         if (r_hs) fifo_data <= swapped;
         if (r_hs && rresp != 2'b00) sts_err <= 1'b1;
         if (abort_req) aborting <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  addr      <= cfg_map_ba;
                  line_addr <= cfg_map_ba;
                  rem       <= line_beats;
                  lines     <= cfg_img_height;
                  reserved  <= '0;
                  aborting  <= 1'b0;
                  sts_busy  <= 1'b1;
                  sts_done  <= 1'b0;
                  sts_err   <= 1'b0;
               end
            end
            LOAD: begin
               state <= abort_req ? DRAIN : WAIT;
            end
            WAIT: begin
               if (abort_req) begin
                  state <= DRAIN;
               end else if (credit_ok) begin
                  state   <= ISSUE;
                  arvalid <= 1'b1;
                  araddr  <= addr;
                  arlen   <= 8'(beats_c - 13'd1);
                  beats   <= beats_c;
               end
            end
            ISSUE: begin
               // An abort cannot withdraw arvalid; it takes effect once the handshake completes.
               if (ar_hs) begin
                  arvalid <= 1'b0;
                  if (discard) begin
                     state <= DRAIN;
                  end else if (line_end) begin
                     lines     <= lines - 11'd1;
                     line_addr <= line_addr + 32'(cfg_stride);
                     addr      <= line_addr + 32'(cfg_stride);
                     rem       <= line_beats;
                     state     <= (lines == 11'd1) ? DRAIN : WAIT;
                  end else begin
                     rem   <= rem_after;
                     addr  <= addr + (32'(beats) << BSH);
                     state <= WAIT;
                  end
               end
            end
            DRAIN: begin
               if (discard) begin
                  if (outstanding == 3'd0) begin
                     state    <= IDLE;
                     sts_busy <= 1'b0;
                  end
               end else if (outstanding == 3'd0 && !r_hs) begin
                  // The final push is on the bus this cycle, so done becomes visible the cycle after it.
                  state    <= DONE;
                  sts_done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               sts_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_frame_reader.sv
`timescale 1ns/1ps
module tb_axi_frame_reader;
   localparam int DATA_W  = 64;
   localparam int FIFO_AW = 5;
   localparam int MAX_OUT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              arready;
   logic [31:0]       araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   logic              cfg_blk_en;
   logic [12:0]       cfg_line_bytes;
   logic [10:0]       cfg_img_height;
   logic [15:0]       cfg_stride;
   logic [31:0]       cfg_map_ba;
   logic [7:0]        cfg_max_burst_length;
   logic [1:0]        cfg_swap_mode;
   logic [FIFO_AW:0]  fifo_words_used;
   logic              fifo_push;
   logic [DATA_W-1:0] fifo_data;
   logic              sts_busy;
   logic              sts_done;
   logic              sts_err;

   axi_frame_reader #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .cfg_blk_en(cfg_blk_en), .cfg_line_bytes(cfg_line_bytes), .cfg_img_height(cfg_img_height),
      .cfg_stride(cfg_stride), .cfg_map_ba(cfg_map_ba), .cfg_max_burst_length(cfg_max_burst_length),
      .cfg_swap_mode(cfg_swap_mode), .fifo_words_used(fifo_words_used),
      .fifo_push(fifo_push), .fifo_data(fifo_data),
      .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Memory slave / monitor state
   bit                ar_en = 1'b1;
   bit                r_en = 1'b1;
   bit                fixed_data = 1'b0;
   int                err_beat = -1;
   int                beat_cnt = 0;
   int                cyc = 0;
   int                last_push_cyc = -1;
   int                done_cyc = -1;
   bit                prev_done = 1'b0;
   int                occ_max = 0;
   int                granted = 0;
   int                pushes_done = 0;
   logic [31:0]       ar_addr_q[$];
   logic [7:0]        ar_len_q[$];
   int                ar_push_q[$];
   logic [DATA_W-1:0] push_q[$];
   logic [31:0]       pend_addr[$];
   int                pend_left[$];

   function automatic logic [63:0] beat_dat(input logic [31:0] a);
      return {a, ~a};
   endfunction

   // Slave and monitor: sample at negedge, drive inputs that take effect at the next posedge.
   initial begin
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (int'(fifo_words_used) + granted - pushes_done > occ_max)
            occ_max = int'(fifo_words_used) + granted - pushes_done;
         if (fifo_push) begin
            push_q.push_back(fifo_data);
            last_push_cyc = cyc;
            pushes_done++;
         end
         if (sts_done && !prev_done) done_cyc = cyc;
         prev_done = sts_done;
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
         if (r_en && !rst && pend_addr.size() > 0) begin
            rvalid = 1'b1;
            rdata  = fixed_data ? 64'h0011_2233_4455_6677 : beat_dat(pend_addr[0]);
            rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
            rlast  = (pend_left[0] == 1);
            beat_cnt++;
            pend_addr[0] = pend_addr[0] + 32'd8;
            pend_left[0] = pend_left[0] - 1;
            if (pend_left[0] == 0) begin
               void'(pend_addr.pop_front());
               void'(pend_left.pop_front());
            end
         end
         arready = ar_en;
         if (arvalid && arready) begin
            ar_addr_q.push_back(araddr);
            ar_len_q.push_back(arlen);
            ar_push_q.push_back(pushes_done);
            granted += int'(arlen) + 1;
            pend_addr.push_back(araddr);
            pend_left.push_back(int'(arlen) + 1);
         end
      end
   end

   task automatic start_frame(input logic [31:0] ba, input logic [12:0] lb, input logic [10:0] h,
                              input logic [15:0] st, input logic [7:0] mb, input logic [1:0] sm);
      @(negedge clk); #1;
      cfg_blk_en = 1'b0;
      cfg_map_ba = ba; cfg_line_bytes = lb; cfg_img_height = h;
      cfg_stride = st; cfg_max_burst_length = mb; cfg_swap_mode = sm;
      ar_addr_q.delete(); ar_len_q.delete(); ar_push_q.delete(); push_q.delete();
      granted = 0; pushes_done = 0; occ_max = 0; beat_cnt = 0;
      last_push_cyc = -1; done_cyc = -1;
      @(negedge clk);
      cfg_blk_en = 1'b1;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (!sts_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({arvalid, fifo_push, sts_busy, sts_done, sts_err, rready} !== 6'b0)
         $display("FAIL reset_ctrl got %b want 000000", {arvalid, fifo_push, sts_busy, sts_done, sts_err, rready});
      else passes++;
      checks++;
      if (araddr !== 32'h0 || arlen !== 8'h0) $display("FAIL reset_ar got addr=%h len=%h want 0/0", araddr, arlen);
      else passes++;
      checks++;
      if (fifo_data !== '0) $display("FAIL reset_data got %h want 0", fifo_data);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (rready !== 1'b1) $display("FAIL rready_after_reset got %b want 1", rready);
      else passes++;
      checks++;
      if (arsize !== 3'd3 || arburst !== 2'b01) $display("FAIL ar_const got size=%0d burst=%b want 3/01", arsize, arburst);
      else passes++;
      checks++;
      if (sts_busy !== 1'b0) $display("FAIL idle_busy got %b want 0", sts_busy);
      else passes++;
   endtask

   task automatic test_basic();
      bit ok;
      int bad;
      logic [31:0] ea[4];
      ea[0] = 32'h1000; ea[1] = 32'h1020; ea[2] = 32'h1080; ea[3] = 32'h10A0;
      start_frame(32'h1000, 13'd64, 11'd2, 16'd128, 8'd4, 2'd0);
      @(posedge clk); #1;
      checks++;
      if (sts_busy !== 1'b1 || arvalid !== 1'b0) $display("FAIL start_e0 got busy=%b arvalid=%b want 1/0", sts_busy, arvalid);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (arvalid !== 1'b0) $display("FAIL start_e1 got arvalid=%b want 0", arvalid);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h1000 || arlen !== 8'd3)
         $display("FAIL start_e2 got v=%b a=%h l=%0d want 1/1000/3", arvalid, araddr, arlen);
      else passes++;
      wait_idle(400, ok);
      checks++;
      if (!ok) $display("FAIL basic_timeout got busy=%b want 0", sts_busy);
      else passes++;
      checks++;
      if (ar_addr_q.size() != 4) $display("FAIL basic_ar_count got %0d want 4", ar_addr_q.size());
      else passes++;
      bad = 0;
      for (int i = 0; i < 4 && i < ar_addr_q.size(); i++)
         if (ar_addr_q[i] !== ea[i] || ar_len_q[i] !== 8'd3) bad++;
      checks++;
      if (bad != 0) $display("FAIL basic_ar_list got %0d bad entries want 0", bad);
      else passes++;
      checks++;
      if (push_q.size() != 16) $display("FAIL basic_push_count got %0d want 16", push_q.size());
      else passes++;
      bad = 0;
      for (int i = 0; i < 16 && i < push_q.size(); i++)
         if (push_q[i] !== beat_dat(32'h1000 + 32'(i / 8) * 32'd128 + 32'(i % 8) * 32'd8)) bad++;
      checks++;
      if (bad != 0) $display("FAIL basic_push_data got %0d bad beats want 0", bad);
      else passes++;
      checks++;
      if (sts_done !== 1'b1 || sts_err !== 1'b0) $display("FAIL basic_status got done=%b err=%b want 1/0", sts_done, sts_err);
      else passes++;
      checks++;
      if (done_cyc != last_push_cyc + 1) $display("FAIL done_timing got cycle %0d want %0d", done_cyc, last_push_cyc + 1);
      else passes++;
   endtask

   task automatic test_4k_split();
      bit ok;
      int bad;
      start_frame(32'h0FF0, 13'd64, 11'd1, 16'd0, 8'd8, 2'd0);
      wait_idle(300, ok);
      checks++;
      if (!ok || ar_addr_q.size() != 2) $display("FAIL split_count got ok=%b ars=%0d want 1/2", ok, ar_addr_q.size());
      else passes++;
      checks++;
      if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h0FF0 || ar_len_q[0] !== 8'd1 ||
          ar_addr_q[1] !== 32'h1000 || ar_len_q[1] !== 8'd5)
         $display("FAIL split_ars got first=%h/%0d want 0ff0/1 and 1000/5",
                  ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx, ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx);
      else passes++;
      bad = (push_q.size() == 8) ? 0 : 1;
      for (int i = 0; i < 8 && i < push_q.size(); i++)
         if (push_q[i] !== beat_dat(32'h0FF0 + 32'(i) * 32'd8)) bad++;
      checks++;
      if (bad != 0 || sts_done !== 1'b1) $display("FAIL split_push got %0d bad done=%b want 0/1", bad, sts_done);
      else passes++;
   endtask

   task automatic test_credit();
      bit ok;
      int hi;
      fifo_words_used = 7'd28;
      start_frame(32'h2000, 13'd128, 11'd1, 16'd0, 8'd8, 2'd0);
      hi = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (arvalid) hi++;
      end
      checks++;
      if (hi != 0 || ar_addr_q.size() != 0) $display("FAIL credit_block got arvalid_cycles=%0d ars=%0d want 0/0", hi, ar_addr_q.size());
      else passes++;
      @(negedge clk);
      fifo_words_used = 7'd24;
      wait_idle(400, ok);
      checks++;
      if (!ok || ar_addr_q.size() != 2 || push_q.size() != 16)
         $display("FAIL credit_run got ok=%b ars=%0d pushes=%0d want 1/2/16", ok, ar_addr_q.size(), push_q.size());
      else passes++;
      checks++;
      if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h2000 || ar_addr_q[1] !== 32'h2040 || ar_len_q[1] !== 8'd7)
         $display("FAIL credit_ars got ars=%0d want 2000/7 then 2040/7", ar_addr_q.size());
      else passes++;
      checks++;
      if (ar_push_q.size() != 2 || ar_push_q[1] < 8)
         $display("FAIL credit_second_ar got pushes_before=%0d want >=8", ar_push_q.size() > 1 ? ar_push_q[1] : -1);
      else passes++;
      checks++;
      if (occ_max > 32) $display("FAIL credit_occupancy got %0d want <=32", occ_max);
      else passes++;
      fifo_words_used = 7'd0;
   endtask

   task automatic test_swap();
      bit ok;
      logic [63:0] exp_tab[3];
      logic [63:0] got;
      exp_tab[0] = 64'h1100_3322_5544_7766;
      exp_tab[1] = 64'h3322_1100_7766_5544;
      exp_tab[2] = 64'h7766_5544_3322_1100;
      fixed_data = 1'b1;
      for (int m = 1; m <= 3; m++) begin
         start_frame(32'h4000, 13'd8, 11'd1, 16'd0, 8'd1, 2'(m));
         wait_idle(100, ok);
         got = (ok && push_q.size() == 1) ? push_q[0] : 64'hx;
         checks++;
         if (got !== exp_tab[m-1]) $display("FAIL swap_mode%0d got %h want %h", m, got, exp_tab[m-1]);
         else passes++;
      end
      fixed_data = 1'b0;
   endtask

   task automatic test_abort();
      bit ok;
      int hi;
      // Two bursts outstanding with R held off, then abort.
      r_en = 1'b0;
      start_frame(32'h3000, 13'd64, 11'd2, 16'd128, 8'd2, 2'd0);
      for (int i = 0; i < 60 && ar_addr_q.size() < 2; i++) @(posedge clk);
      checks++;
      if (ar_addr_q.size() != 2) $display("FAIL abort_setup got ars=%0d want 2", ar_addr_q.size());
      else passes++;
      @(negedge clk);
      cfg_blk_en = 1'b0;
      hi = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (arvalid) hi++;
      end
      r_en = 1'b1;
      wait_idle(200, ok);
      checks++;
      if (!ok || hi != 0 || ar_addr_q.size() != 2)
         $display("FAIL abort_no_ar got ok=%b arvalid_cycles=%0d ars=%0d want 1/0/2", ok, hi, ar_addr_q.size());
      else passes++;
      checks++;
      if (push_q.size() != 0 || pend_addr.size() != 0 || sts_done !== 1'b0)
         $display("FAIL abort_discard got pushes=%0d pend=%0d done=%b want 0/0/0", push_q.size(), pend_addr.size(), sts_done);
      else passes++;
      // Abort while arvalid is waiting for arready.
      ar_en = 1'b0;
      start_frame(32'h5000, 13'd64, 11'd1, 16'd0, 8'd2, 2'd0);
      for (int i = 0; i < 20 && arvalid !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      cfg_blk_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h5000 || arlen !== 8'd1)
         $display("FAIL abort_hold_ar got v=%b a=%h l=%0d want 1/5000/1", arvalid, araddr, arlen);
      else passes++;
      ar_en = 1'b1;
      wait_idle(200, ok);
      checks++;
      if (!ok || ar_addr_q.size() != 1 || push_q.size() != 0 || sts_done !== 1'b0)
         $display("FAIL abort_pending_exit got ok=%b ars=%0d pushes=%0d done=%b want 1/1/0/0",
                  ok, ar_addr_q.size(), push_q.size(), sts_done);
      else passes++;
   endtask

   task automatic test_error();
      bit ok;
      start_frame(32'h6000, 13'd64, 11'd1, 16'd0, 8'd8, 2'd0);
      err_beat = 3;
      wait_idle(200, ok);
      checks++;
      if (!ok || push_q.size() != 8) $display("FAIL err_push_count got ok=%b pushes=%0d want 1/8", ok, push_q.size());
      else passes++;
      checks++;
      if (push_q.size() < 4 || push_q[3] !== beat_dat(32'h6018))
         $display("FAIL err_beat_data got %h want %h", push_q.size() > 3 ? push_q[3] : 64'hx, beat_dat(32'h6018));
      else passes++;
      checks++;
      if (sts_err !== 1'b1 || sts_done !== 1'b1) $display("FAIL err_sticky got err=%b done=%b want 1/1", sts_err, sts_done);
      else passes++;
      err_beat = -1;
      start_frame(32'h6000, 13'd64, 11'd1, 16'd0, 8'd8, 2'd0);
      @(posedge clk); #1;
      checks++;
      if (sts_err !== 1'b0 || sts_done !== 1'b0 || sts_busy !== 1'b1)
         $display("FAIL err_clear_on_start got err=%b done=%b busy=%b want 0/0/1", sts_err, sts_done, sts_busy);
      else passes++;
      wait_idle(200, ok);
      checks++;
      if (!ok || sts_err !== 1'b0 || sts_done !== 1'b1) $display("FAIL clean_frame got ok=%b err=%b done=%b want 1/0/1", ok, sts_err, sts_done);
      else passes++;
   endtask

   initial begin
      rst = 1'b1;
      cfg_blk_en = 1'b0; cfg_line_bytes = '0; cfg_img_height = '0; cfg_stride = '0;
      cfg_map_ba = '0; cfg_max_burst_length = '0; cfg_swap_mode = '0; fifo_words_used = '0;
      test_reset();
      test_basic();
      test_4k_split();
      test_credit();
      test_swap();
      test_abort();
      test_error();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
